branch_predictor: RTL

- Dynamic branch direction predictor for the pipelined MIPS core.
- At fetch, it predicts the direction of the branch at the fetch PC.
- At EX, it consumes the resolved outcome from the branch ALU (beq/bne/bgez/bgt taken bit) to train a table of 2-bit saturating counters.
- It also flags mispredictions to the hazard/flush logic.

---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 102 ++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side prediction bus and EX-side training/statistics bus of the predictor.
// master = pipeline (fetch/EX/hazard logic), slave = branch_predictor.
interface branch_predictor_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
);
  logic             pred_valid_i;
  logic [31:0]      pred_pc_i;
  logic             pred_valid_o;
  logic             pred_taken_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             upd_valid_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_taken_i;
  logic             upd_pred_i;
  logic             mispredict_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  modport master (
    output pred_valid_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i, upd_pred_i,
    input  pred_valid_o, pred_taken_o, pred_idx_o, mispredict_o, branch_cnt_o, miss_cnt_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i, upd_pred_i,
    output pred_valid_o, pred_taken_o, pred_idx_o, mispredict_o, branch_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor; 1-cycle prediction latency; no backpressure.
// Define BPRED_GSHARE_EN to XOR the fetch index with a global history of resolved outcomes.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  branch_predictor_if.slave bp
);
  localparam int NENT = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       tbl [NENT];
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_nxt;
  logic             miss;
  logic             unused_pc_bits;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [IDX_W-1:0] pred_idx_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  assign pc_idx         = bp.pred_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{bp.pred_pc_i[31:IDX_W+2], bp.pred_pc_i[1:0]};

`ifdef BPRED_GSHARE_EN
  // History shifts only at resolution, so a same-cycle predict sees the pre-shift value.
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr <= '0;
    end else if (bp.upd_valid_i) begin
      ghr <= {ghr[IDX_W-2:0], bp.upd_taken_i};
    end
  end

  assign rd_idx = pc_idx ^ ghr;
`else
  assign rd_idx = pc_idx;
`endif

  assign upd_cur = tbl[bp.upd_idx_i];
  assign miss    = bp.upd_valid_i & (bp.upd_taken_i ^ bp.upd_pred_i);

  always_comb begin
    upd_nxt = upd_cur;
    if (bp.upd_taken_i) begin
      if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
    end
  end

  // Reading tbl here while the update writes it gives read-before-write on index collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NENT; i++) tbl[i] <= 2'b01;
    end else if (bp.upd_valid_i) begin
      tbl[bp.upd_idx_i] <= upd_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_valid_q <= bp.pred_valid_i;
      if (bp.pred_valid_i) begin
        pred_taken_q <= tbl[rd_idx][1];
        pred_idx_q   <= rd_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispredict_q <= 1'b0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      mispredict_q <= miss;
      if (bp.upd_valid_i) branch_cnt_q <= branch_cnt_q + CNT_ONE;
      if (miss)           miss_cnt_q   <= miss_cnt_q + CNT_ONE;
    end
  end

  assign bp.pred_valid_o = pred_valid_q;
  assign bp.pred_taken_o = pred_taken_q;
  assign bp.pred_idx_o   = pred_idx_q;
  assign bp.mispredict_o = mispredict_q;
  assign bp.branch_cnt_o = branch_cnt_q;
  assign bp.miss_cnt_o   = miss_cnt_q;
endmodule
